// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchroniser plus stability-counting debouncer with rise/fall pulses
module debounce_sync #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             q_n;
    logic             rise_n;
    logic             fall_n;

    // sync1 is the only flop allowed to go metastable; nothing sits between it and sync2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        q_n     = q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (sync2) begin
                    state_n = CHECK_HIGH;
                    cnt_n   = CNT_ONE;
                end
            end
            CHECK_HIGH: begin
                if (!sync2) begin
                    state_n = STABLE_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_n = STABLE_HIGH;
                    q_n     = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync2) begin
                    state_n = CHECK_LOW;
                    cnt_n   = CNT_ONE;
                end
            end
            CHECK_LOW: begin
                if (sync2) begin
                    state_n = STABLE_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_n = STABLE_LOW;
                    q_n     = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = STABLE_LOW;
            end
        endcase
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
Front-end conditioning stage that sits directly upstream of the d_ff storage element. It takes a raw, asynchronous, bouncy input such as a push-button or switch and produces a clean, clock-synchronous level `q`. That level is what drives the flip-flop's d input. It also emits one-cycle rise and fall pulses for edge-triggered consumers.

Parameters:
- STABLE_CYCLES, 16: number of consecutive clock edges on which the synchronised input must hold a new value before `q` changes. Legal range is 2..2^CNT_W.
- CNT_W, 8: width of the stability counter.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst, input, 1: reset. Asynchronous, active-high.
- din, input, 1: raw asynchronous input. May bounce; no timing relation to clk.
- q, output, 1: debounced, synchronised level. Registered.
- rise, output, 1: one-cycle pulse, asserted in the same cycle that q goes 0->1. Registered.
- fall, output, 1: one-cycle pulse, asserted in the same cycle that q goes 1->0. Registered.

Behaviour:
- Reset (async, rst=1):
  - sync1, sync2, q, rise, fall and cnt all go to 0.
  - FSM goes to STABLE_LOW.
  - Values hold while rst=1, regardless of din or clk.
- Synchroniser:
  - Two-flop chain: sync1<=din, sync2<=sync1.
  - The FSM samples only sync2.
  - No logic sits between sync1 and sync2.
- FSM states: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
- STABLE_LOW:
  - sync2=1 -> go to CHECK_HIGH, cnt<=1.
  - Otherwise hold, cnt<=0.
- CHECK_HIGH:
  - sync2=0 -> go to STABLE_LOW, cnt<=0. The bounce is rejected and no pulse is emitted.
  - sync2=1 and cnt==STABLE_CYCLES-1 -> go to STABLE_HIGH, q<=1, rise<=1, cnt<=0.
  - Otherwise cnt<=cnt+1.
- STABLE_HIGH and CHECK_LOW: mirror images of the two states above, with sync2 inverted and fall instead of rise. The transition to STABLE_LOW sets q<=0 and fall<=1.
- Pulse width: rise and fall default to 0 every cycle and are high for exactly one cycle per accepted transition. rise and fall are never high together.
- Stability rule: sync2 must equal the new value on STABLE_CYCLES consecutive edges. A single opposite sample restarts the count from zero.
- Latency: with din stable from just before edge E0, sync2 is seen at edges E2..E(N+1), where N=STABLE_CYCLES. q and the pulse are visible after edge E(N+1), i.e. N+2 edges. For the default N=16 this is 18 edges.
- Counter width: cnt never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- Reset mid-check: the count in progress is discarded and no pulse is emitted.
- Reset released with din=1: handled as a normal 0->1 transition. q rises, with a rise pulse, N+2 edges after the first edge following release.
- din changing within setup/hold of clk: tolerated. Only sync1 may go metastable. The worst-case effect is a one-cycle shift in latency.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with din=1, then toggle din -> q=0, rise=0, fall=0 throughout; no X values after the first rst assertion.
2. Clean rise: rst released with din=0 for 5 cycles, then din=1 held 30 cycles -> q=1 after exactly the 18th edge from the first edge with din=1; rise=1 for that single cycle; fall=0 throughout.
3. Threshold: from q=0, drive din=1 for 15 cycles then din=0 -> q stays 0 and no rise pulse. Then drive din=1 for 16 cycles -> q=1 at edge 18 with one rise pulse.
4. Bounce train: din pattern 1x3, 0x1, 1x5, 0x2, 1x4 cycles, then 1 held -> q rises 18 edges after the final 0->1 of din; exactly one rise pulse.
5. Clean fall: from q=1, din=0 held 30 cycles -> q=0 at edge 18; fall=1 for one cycle; rise=0.
6. Async reset mid-check: din=1 for 10 cycles, then a rst pulse of 2 ns placed between clock edges -> q, cnt and the pulses clear immediately without waiting for clk. With din still 1, q rises 18 edges after the first edge following release, with one rise pulse.
